pipe_run_ctrl: RTL

Parametrised run controller placed between the top-level clock domain and the pipelined multicycle core.
- Gates the core's advance enable and can hold the core in reset.
- Supports free-run, run-N-cycles, single-step and breakpoint-stop modes.
- Counts elapsed and retired cycles.
- Replaces hand-counted clock edges with a programmable, observable cycle budget and completion/timeout flags.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_run_ctrl_if.sv | 15 +
 rtl/pipe_run_ctrl_bp_match.sv | 19 +
 rtl/pipe_run_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and default widths for the pipeline run controller.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PC_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE = 2'd0,
    MODE_RUNN = 2'd1,
    MODE_STEP = 2'd2,
    MODE_BP   = 2'd3
  } mode_e;

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// Core-facing signals: advance/reset controls out, fetch PC and status back.
interface pipe_run_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic            cpu_en;
  logic            cpu_rst_n;
  logic [PC_W-1:0] pc_if;
  logic            retire;
  logic            halt_seen;

  modport master (output cpu_en, cpu_rst_n, input pc_if, retire, halt_seen);
  modport slave  (input cpu_en, cpu_rst_n, output pc_if, retire, halt_seen);
endinterface

// File: rtl/pipe_run_ctrl_bp_match.sv
// Per-channel PC breakpoint comparators.
module bp_match #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 2
) (
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0]        pc_i,
  output logic [NUM_BP-1:0]      hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_o[i] = bp_en_i[i] && (bp_addr_i[i*PC_W +: PC_W] == pc_i);
    end
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller gating the core's advance enable with free/run-N/step/breakpoint modes.
// state  | meaning
// IDLE   | core held in reset, waiting for start
// LAUNCH | one cycle: reset released, core not yet advancing
// RUN    | core advancing every cycle
// PAUSE  | core frozen; step advances one cycle, resume returns to RUN
// DONE   | core frozen out of reset for inspection; start relaunches
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_CYCLES = 15,
  parameter int PC_W       = PC_W_DEF,
  parameter int NUM_BP     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [CNT_W-1:0]       run_len_i,
  input  logic                   step_i,
  input  logic                   resume_i,
  input  logic                   abort_i,
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
  pipe_run_ctrl_if.master        core,
  output logic [2:0]             state_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic [CNT_W-1:0]       retire_cnt_o,
  output logic [NUM_BP-1:0]      bp_hit_o,
  output logic                   done_o,
  output logic                   timeout_o
);

  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_CYCLES);
  localparam bit             TO_EN = (MAX_CYCLES != 0);

  state_e state_q, state_d;
  mode_e  mode_q;

  logic [CNT_W-1:0]  run_len_q, cycle_cnt_q, retire_cnt_q;
  logic [NUM_BP-1:0] bp_hit_q, bp_raw, bp_eff;
  logic [PC_W-1:0]   blk_pc_q;
  logic              blk_q, timeout_q, done_q, cpu_rst_n_q;
  logic              cpu_en, pc_same, bp_take, to_cond, len_cond, exit_done;
  logic [CNT_W:0]    cnt_inc;

  bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp_match (
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .pc_i      (core.pc_if),
    .hit_o     (bp_raw)
  );

  // One extra bit keeps a saturated counter from ever matching a limit.
  assign cnt_inc   = {1'b0, cycle_cnt_q} + (CNT_W+1)'(1);
  assign to_cond   = TO_EN && (cnt_inc == MAX_W);
  assign len_cond  = (mode_q == MODE_RUNN) && (cnt_inc == {1'b0, run_len_q});
  assign exit_done = core.halt_seen || to_cond || len_cond;

  // A breakpoint that just paused us stays masked until the fetch PC moves.
  assign pc_same = (core.pc_if == blk_pc_q);
  assign bp_eff  = (blk_q && pc_same) ? '0 : bp_raw;
  assign bp_take = (mode_q == MODE_BP) && (|bp_eff);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start_i) state_d = ST_LAUNCH;
        ST_LAUNCH:        state_d = (mode_q == MODE_STEP) ? ST_PAUSE : ST_RUN;
        ST_RUN: begin
          if (exit_done)    state_d = ST_DONE;
          else if (bp_take) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (step_i) begin
            if (exit_done) state_d = ST_DONE;
          end else if (resume_i && mode_q != MODE_STEP) begin
            state_d = ST_RUN;
          end
        end
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:   cpu_en = 1'b1;
      ST_PAUSE: cpu_en = step_i;
      default:  cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= MODE_FREE;
      run_len_q    <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      bp_hit_q     <= '0;
      blk_pc_q     <= '0;
      blk_q        <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      done_q      <= (state_d == ST_DONE);
      cpu_rst_n_q <= (state_d != ST_IDLE);
      if (state_d == ST_LAUNCH) begin
        mode_q       <= mode_e'(mode_i);
        run_len_q    <= (run_len_i == '0) ? CNT_W'(1) : run_len_i;
        cycle_cnt_q  <= '0;
        retire_cnt_q <= '0;
        bp_hit_q     <= '0;
        blk_q        <= 1'b0;
        timeout_q    <= 1'b0;
      end else begin
        if (cpu_en) begin
          if (!(&cycle_cnt_q)) cycle_cnt_q <= cnt_inc[CNT_W-1:0];
          if (core.retire && !(&retire_cnt_q)) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
          if (to_cond && !abort_i && !core.halt_seen) timeout_q <= 1'b1;
        end
        if (state_q == ST_RUN && state_d == ST_PAUSE) begin
          bp_hit_q <= bp_hit_q | bp_eff;
          blk_q    <= 1'b1;
          blk_pc_q <= core.pc_if;
        end else if (blk_q && !pc_same) begin
          blk_q <= 1'b0;
        end
      end
    end
  end

  assign core.cpu_en    = cpu_en;
  assign core.cpu_rst_n = cpu_rst_n_q;
  assign state_o        = state_q;
  assign cycle_cnt_o    = cycle_cnt_q;
  assign retire_cnt_o   = retire_cnt_q;
  assign bp_hit_o       = bp_hit_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;

endmodule
